// File: rtl/time_display_scan.sv
// Drives a 4-digit common-anode 7-segment display from the BCD time bus. Frames are tear-free, the time is range-checked and a leading zero is blanked.
// Latency: a capture reaches the shadow in 1 cycle. It is shown after the next frame wrap plus 2 cycles (one dead cycle, one output register).
// Backpressure: none. time_valid and sec_tick are always accepted, and the scan free-runs.
module time_display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hour1,
  input  logic [3:0] hour2,
  input  logic [3:0] min1,
  input  logic [3:0] min2,
  input  logic       time_valid,
  input  logic       sec_tick,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_done
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  // The first edge after reset only arms the scan, so slot 0 starts with cnt=0 on that edge.
  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic [3:0] sh_h1, sh_h2, sh_m1, sh_m2;
  logic [3:0] d_h1, d_h2, d_m1, d_m2;
  logic       colon_on;

  logic       wrap;
  logic       disp_ok;
  logic       lz_blank;
  logic [3:0] cur;
  logic [3:0] nxt_an;
  logic [6:0] nxt_seg;
  logic       nxt_dp;

  // BCD to active-low segments a..g. Non-digit codes cannot reach here once the range check passes.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign wrap    = run && (cnt == CNT_MAX) && (idx == 2'd3);
  assign disp_ok = !((d_h1 > 4'd2) || (d_h2 > 4'd9) ||
                     ((d_h1 == 4'd2) && (d_h2 > 4'd3)) ||
                     (d_m1 > 4'd5) || (d_m2 > 4'd9));
  assign lz_blank = BLANK_LZ && disp_ok && (idx == 2'd0) && (d_h1 == 4'd0);

  // Decode the current scan position and snapshot into the next output pattern.
  always_comb begin
    nxt_an  = 4'hF;
    nxt_seg = 7'h7F;
    nxt_dp  = 1'b1;
    case (idx)
      2'd0:    cur = d_h1;
      2'd1:    cur = d_h2;
      2'd2:    cur = d_m1;
      default: cur = d_m2;
    endcase
    // cnt=0 is the anti-ghosting dead cycle, so the outputs stay blank there.
    if (run && (cnt != '0) && !lz_blank) begin
      nxt_an  = ~(4'b1000 >> idx);
      nxt_seg = disp_ok ? enc(cur) : 7'h3F;
      nxt_dp  = !((idx == 2'd1) && colon_on && disp_ok);
    end
  end

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (cnt == CNT_MAX) begin
          cnt <= '0;
          idx <= idx + 2'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Shadow capture, the frame-boundary snapshot and the colon toggle.
  // The snapshot copies the pre-edge shadow, so a coincident capture is shown one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_h1    <= 4'd0;
      sh_h2    <= 4'd0;
      sh_m1    <= 4'd0;
      sh_m2    <= 4'd0;
      d_h1     <= 4'd0;
      d_h2     <= 4'd0;
      d_m1     <= 4'd0;
      d_m2     <= 4'd0;
      colon_on <= 1'b1;
    end else begin
      if (time_valid) begin
        sh_h1 <= hour1;
        sh_h2 <= hour2;
        sh_m1 <= min1;
        sh_m2 <= min2;
      end
      if (wrap) begin
        d_h1 <= sh_h1;
        d_h2 <= sh_h2;
        d_m1 <= sh_m1;
        d_m2 <= sh_m2;
      end
      if (sec_tick) begin
        colon_on <= ~colon_on;
      end
    end
  end

  // Register all display pins and the frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= 4'hF;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an_n       <= nxt_an;
      seg_n      <= nxt_seg;
      dp_n       <= nxt_dp;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan with SCAN_DIV=4. A behavioural model queues the expected outputs for every edge.
// Latency: each edge's expectation is popped and compared half a cycle later.
// Backpressure: not applicable. Stimulus is a linear list of directed steps.
module tb_time_display_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] hour1, hour2, min1, min2;
  logic       time_valid;
  logic       sec_tick;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_done;

  time_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .hour1(hour1), .hour2(hour2), .min1(min1), .min2(min2),
    .time_valid(time_valid), .sec_tick(sec_tick),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    bit         chk_seg;
  } exp_t;

  exp_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  // Spec-level model state: scan position since the arm edge, shadow, displayed snapshot, colon.
  int         s;
  logic [3:0] sh  [4];
  logic [3:0] dsp [4];
  logic       colon;

  logic [6:0] enc_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic bit snap_ok();
    return !((dsp[0] > 2) || (dsp[1] > 9) || (dsp[0] == 2 && dsp[1] > 3) ||
             (dsp[2] > 5) || (dsp[3] > 9));
  endfunction

  task automatic model_reset();
    s = -1;
    colon = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sh[i]  = 4'd0;
      dsp[i] = 4'd0;
    end
  endtask

  // One clock: expected outputs from pre-edge model state, model update, then the negedge compare.
  task automatic step();
    exp_t e;
    exp_t g;
    int slot;
    @(posedge clk);
    edge_no++;
    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0; e.chk_seg = 1'b1;
    if (s >= 0) begin
      slot = (s / 4) % 4;
      e.fd = ((s % 16) == 15);
      if ((s % 4) != 0) begin
        if (snap_ok() && slot == 0 && dsp[0] == 4'd0) begin
          e.chk_seg = 1'b0;
        end else begin
          e.an  = ~(4'b1000 >> slot);
          e.seg = snap_ok() ? enc_tab[dsp[slot]] : 7'h3F;
          e.dp  = !(slot == 1 && colon && snap_ok());
        end
      end
      if ((s % 16) == 15) begin
        for (int i = 0; i < 4; i++) dsp[i] = sh[i];
      end
    end
    if (time_valid) begin
      sh[0] = hour1; sh[1] = hour2; sh[2] = min1; sh[3] = min2;
    end
    if (sec_tick) colon = ~colon;
    s++;
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    chk($sformatf("an_n@%0d", edge_no), {4'h0, an_n}, {4'h0, g.an});
    if (g.chk_seg) chk($sformatf("seg_n@%0d", edge_no), {1'b0, seg_n}, {1'b0, g.seg});
    chk($sformatf("dp_n@%0d", edge_no), {7'h0, dp_n}, {7'h0, g.dp});
    chk($sformatf("frame_done@%0d", edge_no), {7'h0, frame_done}, {7'h0, g.fd});
  endtask

  task automatic capture(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    hour1 = a; hour2 = b; min1 = c; min2 = d;
    time_valid = 1'b1;
    step();
    time_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < 16 && (s % 16) != pos; i++) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"},  {4'h0, an_n},  8'h0F);
    chk({tag, "_seg"}, {1'b0, seg_n}, 8'h7F);
    chk({tag, "_dp"},  {7'h0, dp_n},  8'h01);
    chk({tag, "_fd"},  {7'h0, frame_done}, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    time_valid = 1'b0;
    sec_tick = 1'b0;
    hour1 = 4'd0; hour2 = 4'd0; min1 = 4'd0; min2 = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Power-on display: 00:00 with Hour1 blanked, frame_done every 16 cycles.
    run(40);

    // Mid-frame capture: the old value holds to the frame end.
    run_to(6);
    capture(4'd1, 4'd2, 4'd3, 4'd4);
    run(40);

    // Capture on the wrap edge: shown only after the following wrap.
    run_to(15);
    capture(4'd2, 4'd3, 4'd5, 4'd9);
    run(40);

    // Out-of-range snapshots show dashes with the colon off.
    capture(4'd2, 4'd4, 4'd0, 4'd0);
    run(40);
    capture(4'd1, 4'd2, 4'd6, 4'd0);
    run(40);

    // Valid time with a leading zero, then a colon toggling every 10 cycles.
    capture(4'd0, 4'd7, 4'd4, 4'd5);
    run(36);
    for (int i = 0; i < 80; i++) begin
      sec_tick = ((i % 10) == 0);
      step();
    end
    sec_tick = 1'b0;

    // Asynchronous reset in the middle of slot 2.
    run_to(10);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    model_reset();
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
